// File: rtl/seq_cla_subtractor_pkg.sv
// Shared types and constants for the sequential nibble-serial CLA subtractor.
package seq_cla_subtractor_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic borrow;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/seq_cla_subtractor_if.sv
// Operand/result handshake bundle between the subtractor and its producer/consumer.
interface seq_cla_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             borrow_out;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, d, borrow_out, ovf, zero
    );

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, d, borrow_out, ovf, zero
    );
endinterface

// File: rtl/seq_cla_subtractor_nibble_cla_stage.sv
// Combinational 4-bit generate/propagate carry-lookahead adder stage.
module nibble_cla_stage
    import seq_cla_subtractor_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] s,
    output logic                c_out
);
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Fully flattened lookahead: every carry depends only on g, p and c_in.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s     = p ^ c[NIBBLE_W-1:0];
    assign c_out = c[NIBBLE_W];
endmodule

// File: rtl/seq_cla_subtractor.sv
// Nibble-serial subtractor D = A - B - borrow_in: one CLA nibble per cycle, valid/ready on both sides.
module seq_cla_subtractor
    import seq_cla_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_cla_subtractor_if.slave  bus
);
    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned IDX_W   = CNT_W + 2;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     nb_r;
    logic [WIDTH-1:0]     d_r;
    logic                 carry;
    logic [CNT_W-1:0]     cnt;
    flags_t               flags;
    logic                 out_valid_r;

    logic                 accept_c;
    logic                 last_c;
    logic [IDX_W-1:0]     idx_c;
    logic [NIBBLE_W-1:0]  a_nib_c;
    logic [NIBBLE_W-1:0]  b_nib_c;
    logic [NIBBLE_W-1:0]  s_nib_c;
    logic                 c_out_c;
    logic [WIDTH-1:0]     d_full_c;

    assign accept_c = (state == ST_IDLE) && bus.in_valid;
    assign last_c   = (state == ST_CALC) && (cnt == CNT_W'(NIBBLES - 1));
    assign idx_c    = IDX_W'(cnt) * IDX_W'(NIBBLE_W);
    assign a_nib_c  = a_r[idx_c +: NIBBLE_W];
    assign b_nib_c  = nb_r[idx_c +: NIBBLE_W];

    nibble_cla_stage u_stage (
        .a     (a_nib_c),
        .b     (b_nib_c),
        .c_in  (carry),
        .s     (s_nib_c),
        .c_out (c_out_c)
    );

    // Difference as it will look after this cycle's nibble lands.
    always_comb begin
        d_full_c                    = d_r;
        d_full_c[idx_c +: NIBBLE_W] = s_nib_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_nxt = ST_CALC;
            ST_CALC: if (last_c)        state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Operand, carry, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            nb_r        <= '0;
            d_r         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            flags       <= '0;
            out_valid_r <= 1'b0;
        end else if (accept_c) begin
            a_r   <= bus.a;
            nb_r  <= ~bus.b;
            carry <= ~bus.borrow_in;
            cnt   <= '0;
            d_r   <= '0;
        end else if (state == ST_CALC) begin
            d_r   <= d_full_c;
            carry <= c_out_c;
            if (last_c) begin
                cnt          <= '0;
                flags.borrow <= ~c_out_c;
                // a_r msb equal to ~b msb means the operand signs differ.
                flags.ovf    <= (a_r[WIDTH-1] == nb_r[WIDTH-1])
                              & (s_nib_c[NIBBLE_W-1] != a_r[WIDTH-1]);
                flags.zero   <= (d_full_c == '0);
                out_valid_r  <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if ((state == ST_DONE) && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.out_valid  = out_valid_r;
    assign bus.d          = d_r;
    assign bus.borrow_out = flags.borrow;
    assign bus.ovf        = flags.ovf;
    assign bus.zero       = flags.zero;
endmodule
